// File: rtl/min_max_track_if.sv
// Sample-in / frame-result-out handshake bundle for min_max_track.
// Index signals exist only when MIN_MAX_TRACK_INDEX_EN is defined.
interface min_max_track_if #(
  parameter int CNT_W = 8
);
  logic             In_Valid;
  logic             In_Ready;
  logic [7:0]       Data;
  logic             Last;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [7:0]       Min;
  logic [7:0]       Max;
  logic [CNT_W-1:0] Count;
  logic             Sat;
`ifdef MIN_MAX_TRACK_INDEX_EN
  logic [CNT_W-1:0] Min_Idx;
  logic [CNT_W-1:0] Max_Idx;
`endif

  modport slave (
    input  In_Valid, Data, Last, Out_Ready,
    output In_Ready, Out_Valid,
    output Min, Max, Count, Sat
`ifdef MIN_MAX_TRACK_INDEX_EN
    , Min_Idx, Max_Idx
`endif
  );

  modport master (
    output In_Valid, Data, Last, Out_Ready,
    input  In_Ready, Out_Valid,
    input  Min, Max, Count, Sat
`ifdef MIN_MAX_TRACK_INDEX_EN
    , Min_Idx, Max_Idx
`endif
  );
endinterface

// File: rtl/min_max_track.sv
// Per-frame unsigned min/max/count tracker with a held result.
// Optional extreme-position outputs: define MIN_MAX_TRACK_INDEX_EN.
module min_max_track #(
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  min_max_track_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_nx;

  logic [7:0]       min_q;
  logic [7:0]       max_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
`ifdef MIN_MAX_TRACK_INDEX_EN
  logic [CNT_W-1:0] min_idx_q;
  logic [CNT_W-1:0] max_idx_q;
`endif

  logic in_rdy;
  logic out_vld;
  logic take;
  logic give;

  assign take = bus.In_Valid & in_rdy;
  assign give = out_vld & bus.Out_Ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = bus.Last ? HOLD : ACCUM;
      ACCUM:   if (take && bus.Last) state_nx = HOLD;
      HOLD:    if (give) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    unique case (state)
      IDLE:    in_rdy  = ~rst;
      ACCUM:   in_rdy  = ~rst;
      HOLD:    out_vld = 1'b1;
      default: ;
    endcase
  end

  // Before saturation cnt_q equals the zero-based position of the
  // incoming sample; once saturated it holds, and so does the position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
`ifdef MIN_MAX_TRACK_INDEX_EN
      min_idx_q <= '0;
      max_idx_q <= '0;
`endif
    end else if (take) begin
      if (state == IDLE) begin
        min_q     <= bus.Data;
        max_q     <= bus.Data;
        cnt_q     <= CNT_W'(1);
        sat_q     <= 1'b0;
`ifdef MIN_MAX_TRACK_INDEX_EN
        min_idx_q <= '0;
        max_idx_q <= '0;
`endif
      end else begin
        if (bus.Data < min_q) begin
          min_q     <= bus.Data;
`ifdef MIN_MAX_TRACK_INDEX_EN
          min_idx_q <= cnt_q;
`endif
        end
        if (bus.Data > max_q) begin
          max_q     <= bus.Data;
`ifdef MIN_MAX_TRACK_INDEX_EN
          max_idx_q <= cnt_q;
`endif
        end
        if (cnt_q == CNT_MAX) sat_q <= 1'b1;
        else                  cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.In_Ready  = in_rdy;
  assign bus.Out_Valid = out_vld;
  assign bus.Min       = min_q;
  assign bus.Max       = max_q;
  assign bus.Count     = cnt_q;
  assign bus.Sat       = sat_q;
`ifdef MIN_MAX_TRACK_INDEX_EN
  assign bus.Min_Idx   = min_idx_q;
  assign bus.Max_Idx   = max_idx_q;
`endif
endmodule
